// File: rtl/alu_seq_driver.sv
// Command front end for the 32-bit combinational ALU: loads operands, launches an
// execute, captures y/t one cycle later and holds the result until it is consumed.
module alu_seq_driver #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_sel,
  input  logic [31:0]      cmd_data,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [2:0]       alu_f,
  input  logic [31:0]      alu_y,
  input  logic [2:0]       alu_t,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_y,
  output logic [2:0]       res_t,
  output logic [2:0]       res_f,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  localparam logic [1:0] SEL_LDA = 2'b00;
  localparam logic [1:0] SEL_LDB = 2'b01;
  localparam logic [1:0] SEL_EXE = 2'b10;
  localparam logic [1:0] SEL_CLR = 2'b11;

  state_t           state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d, res_y_q, res_y_d;
  logic [2:0]       f_q, f_d, res_t_q, res_t_d, res_f_q, res_f_d;
  logic             res_valid_q, res_valid_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;

  // state_q resets asynchronously to IDLE, so cmd_ready is high while rstn is low
  assign cmd_ready = (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    f_d         = f_q;
    res_y_d     = res_y_q;
    res_t_d     = res_t_q;
    res_f_d     = res_f_q;
    res_valid_d = res_valid_q;
    op_cnt_d    = op_cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_sel)
            SEL_LDA: a_d = cmd_data;
            SEL_LDB: b_d = cmd_data;
            SEL_EXE: begin
              f_d     = cmd_data[2:0];
              state_d = EXEC;
            end
            SEL_CLR: begin
              a_d      = '0;
              b_d      = '0;
              f_d      = '0;
              op_cnt_d = '0;
            end
            default: ;
          endcase
        end
      end
      EXEC: begin
        // A/B/F have been stable for a full cycle; the ALU output is settled
        res_y_d     = alu_y;
        res_t_d     = alu_t;
        res_f_d     = f_q;
        res_valid_d = 1'b1;
        op_cnt_d    = op_cnt_q + 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      f_q         <= '0;
      res_y_q     <= '0;
      res_t_q     <= '0;
      res_f_q     <= '0;
      res_valid_q <= 1'b0;
      op_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      f_q         <= f_d;
      res_y_q     <= res_y_d;
      res_t_q     <= res_t_d;
      res_f_q     <= res_f_d;
      res_valid_q <= res_valid_d;
      op_cnt_q    <= op_cnt_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_f     = f_q;
  assign res_y     = res_y_q;
  assign res_t     = res_t_q;
  assign res_f     = res_f_q;
  assign res_valid = res_valid_q;
  assign op_cnt    = op_cnt_q;

endmodule

// File: doc/alu_seq_driver.md
# alu_seq_driver

Sequential command front end for the 32-bit combinational ALU. It takes operand-load and execute commands over a valid/ready stream and drives the ALU's `a`, `b` and `f` inputs from internal registers. It captures the ALU's `y` and `t` outputs one cycle after an execute and presents them on a valid/ready result port that holds its value under backpressure. It sits between the board I/O or debug controller and the ALU instance.

## Interface
Parameters
- CNT_W, 16, width of the executed-operation counter.

Ports
- clk  in  1  system clock; all state changes on its rising edge.
- rstn  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_sel  in  2  command type: 00 load A, 01 load B, 10 execute, 11 clear.
- cmd_data  in  32  operand for loads; bits [2:0] are the function code for execute.
- alu_a  out  32  to ALU operand a; equals the A register.
- alu_b  out  32  to ALU operand b; equals the B register.
- alu_f  out  3  to ALU function select; equals the F register.
- alu_y  in  32  from ALU result.
- alu_t  in  3  from ALU compare flags (t[0] eq, t[1] signed lt, t[2] unsigned lt; valid for f=000 only).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_y  out  32  captured result.
- res_t  out  3  captured flags.
- res_f  out  3  function code that produced the result.
- op_cnt  out  CNT_W  count of completed executes; wraps modulo 2^CNT_W.

## Operation
- Registers: A, B, F, res_y, res_t, res_f, res_valid, op_cnt, state. All reset to 0; state resets to IDLE.
- States:
  - IDLE: cmd_ready=1.
  - EXEC: cmd_ready=0; one cycle for the ALU to settle.
  - HOLD: cmd_ready=0; result offered on the result port.
- cmd_ready is combinational: it is 1 exactly when state is IDLE, including while rstn is low.
- Accepted command in IDLE (cmd_valid & cmd_ready):
  - 00: A <= cmd_data.
  - 01: B <= cmd_data.
  - 11: A, B, F and op_cnt <= 0. Result registers are unchanged.
  - For 00, 01 and 11 the block stays in IDLE.
  - 10: F <= cmd_data[2:0]; state <= EXEC. cmd_data[31:3] is ignored.
- EXEC: on the next edge:
  - res_y <= alu_y, res_t <= alu_t, res_f <= F.
  - res_valid <= 1; op_cnt <= op_cnt + 1 (wraps); state <= HOLD.
- HOLD:
  - res_y, res_t, res_f and res_valid stay stable until res_valid & res_ready.
  - On that edge res_valid <= 0 and state <= IDLE.
- Commands presented outside IDLE are not accepted. The source must hold them; the block ignores and does not latch them.
- A, B and F never change outside IDLE, so the ALU inputs are stable throughout EXEC and HOLD.
- rstn low at any point, including mid-EXEC or mid-HOLD, abandons the operation immediately: res_valid=0, outputs return to reset values, the in-flight result is lost, and op_cnt is not incremented.
- No internal interpretation of t: flags are passed through as captured. Flags for f≠000 are whatever the ALU drives (000).

## Timing
- Load accepted at edge k: alu_a or alu_b shows the new value after edge k.
- Execute accepted at edge k:
  - alu_f is updated after edge k; state is EXEC during cycle k..k+1.
  - Capture happens at edge k+1; res_valid is high after edge k+1. Latency is one cycle from acceptance to res_valid.
- With res_ready held high: transfer at edge k+2, state is IDLE and cmd_ready=1 after edge k+2.
  - Peak rate is one execute per 3 cycles.
  - Load–load–execute sequences cost one cycle per load.
- res_ready is ignored while res_valid=0.
- No combinational path from res_ready or cmd_valid to any output.

## Test plan
- Load A=5, B=3, execute f=000, res_ready=1 → res_y=0x00000002, res_t=000, res_f=000, op_cnt=1, res_valid high exactly one cycle.
- A=3, B=5, f=000 → res_y=0xFFFFFFFE, res_t=110. Then A=0xFFFFFFFF, B=1, f=000 → res_y=0xFFFFFFFE, res_t=010.
- A=0x80000000, B=4, execute f=111, then f=101, then f=110 (B unchanged) → res_y=0xF8000000, 0x08000000, 0x00000000 in order.
- Backpressure: execute f=001 with A=7, B=9, res_ready=0 for 5 cycles, cmd_valid=1 with load A=0x1234 held throughout:
  - res_y=0x00000010 stable, cmd_ready=0, alu_a stays 7.
  - After res_ready pulse: IDLE, then the load is accepted.
- CNT_W=2: five executes → op_cnt sequence 1,2,3,0,1. Then clear → op_cnt=0, alu_a=alu_b=0, alu_f=0, res_y unchanged.
- Assert rstn low during HOLD with res_ready=0 → res_valid=0, op_cnt=0, cmd_ready=1 immediately; after release the block accepts commands normally.
